// File: rtl/regdisp_tracked.sv
// regdisp_tracked: one upstream register port fanned out to FORWARD_NUM
// downstream ports. Address decode picks a channel from BASE_ADDR/ADDR_MASK,
// a single transaction is in flight at a time, and every request gets exactly
// one upstream response: forwarded data, a decode/command error, or a timeout.
module regdisp_tracked #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int FORWARD_NUM = 3,
  parameter logic [FORWARD_NUM*ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [FORWARD_NUM*ADDR_WIDTH-1:0] ADDR_MASK = '0,
  parameter logic [FORWARD_NUM-1:0] OFFSET_MODE        = '0,
  parameter logic [FORWARD_NUM-1:0] INSERT_FORWARD_DFF = '0,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RD_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              upstream__req_vld,
  output logic                              upstream__req_rdy,
  input  logic [ADDR_WIDTH-1:0]             upstream__addr,
  input  logic                              upstream__wr_en,
  input  logic                              upstream__rd_en,
  input  logic [DATA_WIDTH-1:0]             upstream__wr_data,
  output logic                              upstream__ack_vld,
  output logic [DATA_WIDTH-1:0]             upstream__rd_data,
  output logic                              upstream__err,
  output logic [FORWARD_NUM-1:0]            downstream__req_vld,
  output logic [FORWARD_NUM*ADDR_WIDTH-1:0] downstream__addr,
  output logic [FORWARD_NUM-1:0]            downstream__wr_en,
  output logic [FORWARD_NUM-1:0]            downstream__rd_en,
  output logic [FORWARD_NUM*DATA_WIDTH-1:0] downstream__wr_data,
  input  logic [FORWARD_NUM-1:0]            downstream__ack_vld,
  input  logic [FORWARD_NUM*DATA_WIDTH-1:0] downstream__rd_data,
  output logic [15:0]                       err_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYC);

  state_t                   state, state_nxt;
  logic [FORWARD_NUM-1:0]   hit_oh, sel_oh, dff_vld, ds_vld;
  logic [ADDR_WIDTH-1:0]    fwd_addr, addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q, resp_data, ack_data;
  logic                     wr_q, rd_q, resp_err;
  logic                     hit, cmd_ok, latch, cap_ack, to_fire;
  logic                     ack_sel, dff_sel, to_hit;
  logic [31:0]              cnt;

  // Region decode: scan from the top so the lowest matching channel wins.
  always_comb begin
    hit_oh   = '0;
    fwd_addr = upstream__addr;
    for (int k = FORWARD_NUM - 1; k >= 0; k--) begin
      if ((upstream__addr & ~ADDR_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
          BASE_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_oh    = '0;
        hit_oh[k] = 1'b1;
        fwd_addr  = OFFSET_MODE[k] ? (upstream__addr & ADDR_MASK[k*ADDR_WIDTH +: ADDR_WIDTH])
                                   : upstream__addr;
      end
    end
  end

  assign hit     = |hit_oh;
  assign cmd_ok  = upstream__wr_en ^ upstream__rd_en;
  assign ack_sel = |(downstream__ack_vld & sel_oh);
  assign dff_sel = |(sel_oh & INSERT_FORWARD_DFF);
  assign to_hit  = (TIMEOUT_CYC != 0) && (cnt == TO_LIMIT);

  // Read data of the selected channel (sel_oh is one-hot while waiting).
  always_comb begin
    ack_data = '0;
    for (int k = 0; k < FORWARD_NUM; k++) begin
      if (sel_oh[k]) ack_data = ack_data | downstream__rd_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state logic. The ISSUE cycle of an unregistered channel is already
  // the first wait cycle (cnt==0), so acks and timeouts are honoured there;
  // a registered channel issues one cycle later, so ISSUE only hands off.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    cap_ack   = 1'b0;
    to_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (upstream__req_vld) begin
          latch     = 1'b1;
          state_nxt = (cmd_ok && hit) ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (dff_sel) begin
          state_nxt = WAIT;
        end else if (ack_sel) begin
          cap_ack   = 1'b1;
          state_nxt = RESP;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (ack_sel) begin
          cap_ack   = 1'b1;
          state_nxt = RESP;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, channel select, wait counter, forward strobe stage, error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_oh  <= '0;
      cnt     <= '0;
      dff_vld <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dff_vld <= (state == ISSUE) ? (sel_oh & INSERT_FORWARD_DFF) : '0;
      if (latch) begin
        sel_oh <= cmd_ok ? hit_oh : '0;
        cnt    <= '0;
      end else if (state == WAIT || (state == ISSUE && !dff_sel)) begin
        cnt <= cnt + 32'd1;
      end
      if (state == RESP && resp_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  // Transaction payload and response data; outputs are gated, so no reset needed.
  always_ff @(posedge clk) begin
    if (latch) begin
      addr_q  <= fwd_addr;
      wr_q    <= upstream__wr_en;
      rd_q    <= upstream__rd_en;
      wdata_q <= upstream__wr_data;
      if (!(cmd_ok && hit)) begin
        resp_err  <= 1'b1;
        resp_data <= ERR_RD_DATA;
      end
    end
    if (cap_ack) begin
      resp_err  <= 1'b0;
      resp_data <= wr_q ? '0 : ack_data;
    end
    if (to_fire) begin
      resp_err  <= 1'b1;
      resp_data <= ERR_RD_DATA;
    end
  end

  assign upstream__req_rdy = (state == IDLE);
  assign upstream__ack_vld = (state == RESP);
  assign upstream__rd_data = (state == RESP) ? resp_data : '0;
  assign upstream__err     = (state == RESP) && resp_err;

  // Downstream drive: only the channel carrying the request strobe is non-zero.
  always_comb begin
    ds_vld              = '0;
    downstream__addr    = '0;
    downstream__wr_en   = '0;
    downstream__rd_en   = '0;
    downstream__wr_data = '0;
    for (int k = 0; k < FORWARD_NUM; k++) begin
      ds_vld[k] = INSERT_FORWARD_DFF[k] ? dff_vld[k] : ((state == ISSUE) && sel_oh[k]);
      if (ds_vld[k]) begin
        downstream__addr[k*ADDR_WIDTH +: ADDR_WIDTH]    = addr_q;
        downstream__wr_en[k]                            = wr_q;
        downstream__rd_en[k]                            = rd_q;
        downstream__wr_data[k*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
      end
    end
  end

  assign downstream__req_vld = ds_vld;

endmodule
